// File: rtl/hamming_pkg.sv
// Shared widths, bit-position maps and pure encode/syndrome helpers
// for the Hamming(12,8) codec.
package hamming_pkg;

   localparam int DATA_W = 8;
   localparam int CODE_W = 12;
   localparam int SYN_W  = 4;

   // 1-based codeword positions of the parity bits and of d0..d7
   localparam int PAR_POS  [SYN_W]  = '{1, 2, 4, 8};
   localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

   function automatic logic [SYN_W-1:0] ham_syndrome(input logic [CODE_W-1:0] code);
      logic [SYN_W-1:0] s;
      s = '0;
      for (int k = 0; k < SYN_W; k++) begin
         for (int p = 1; p <= CODE_W; p++) begin
            if (((p >> k) & 1) != 0) begin
               s[k] = s[k] ^ code[p-1];
            end
         end
      end
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] ham_extract(input logic [CODE_W-1:0] code);
      logic [DATA_W-1:0] d;
      d = '0;
      for (int i = 0; i < DATA_W; i++) begin
         d[i] = code[DATA_POS[i]-1];
      end
      return d;
   endfunction

   // Parity slots start at zero, so the syndrome of the partial word is the parity
   function automatic logic [CODE_W-1:0] ham_encode(input logic [DATA_W-1:0] data);
      logic [CODE_W-1:0] c;
      logic [SYN_W-1:0]  s;
      c = '0;
      for (int i = 0; i < DATA_W; i++) begin
         c[DATA_POS[i]-1] = data[i];
      end
      s = ham_syndrome(c);
      for (int k = 0; k < SYN_W; k++) begin
         c[PAR_POS[k]-1] = s[k];
      end
      return c;
   endfunction

endpackage

// File: rtl/hamming_dec.sv
// Combinational Hamming(12,8) decode: syndrome, single-bit correction, data extract.
// With HAMMING_SECDED_EN an overall parity bit distinguishes single from double errors.
module hamming_dec
   import hamming_pkg::*;
(
   input  logic [CODE_W-1:0] code_i,
`ifdef HAMMING_SECDED_EN
   input  logic              par_i,
   output logic              dbl_o,
`endif
   output logic [DATA_W-1:0] data_o,
   output logic [SYN_W-1:0]  syn_o,
   output logic              corr_o
);

   logic [SYN_W-1:0]  syn;
   logic [CODE_W-1:0] flip_mask;
   logic              in_range;
   logic              do_fix;

   assign syn      = ham_syndrome(code_i);
   assign in_range = (syn != '0) && (syn <= SYN_W'(CODE_W));

`ifdef HAMMING_SECDED_EN
   logic par_all;

   assign par_all = (^code_i) ^ par_i;
   assign do_fix  = in_range && par_all;
   // A zero syndrome with odd overall parity means only par_i flipped
   assign corr_o  = do_fix || ((syn == '0) && par_all);
   assign dbl_o   = (syn != '0) && !do_fix;
`else
   assign do_fix  = in_range;
   assign corr_o  = in_range;
`endif

   for (genvar gi = 0; gi < CODE_W; gi++) begin : g_flip
      assign flip_mask[gi] = do_fix && (syn == SYN_W'(gi + 1));
   end

   assign data_o = ham_extract(code_i ^ flip_mask);
   assign syn_o  = syn;

endmodule

// File: rtl/hamming.sv
// Registered Hamming(12,8) encoder and decoder sharing one clock, independent paths.
// Define HAMMING_SECDED_EN to add overall parity (par_out/par_in) and double-error flag (err_dbl).
module hamming
   import hamming_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   output logic [CODE_W-1:0] data_out,
   input  logic [CODE_W-1:0] code_in,
   output logic [DATA_W-1:0] dec_data,
   output logic [SYN_W-1:0]  syndrome,
   output logic              err_corr
`ifdef HAMMING_SECDED_EN
   ,
   output logic              par_out,
   input  logic              par_in,
   output logic              err_dbl
`endif
);

   logic [CODE_W-1:0] code_q, code_d;
   logic [DATA_W-1:0] dec_q, dec_d;
   logic [SYN_W-1:0]  syn_q, syn_d;
   logic              corr_q, corr_d;

   assign code_d = ham_encode(data_in);

`ifdef HAMMING_SECDED_EN
   logic par_q, par_d;
   logic dbl_q, dbl_d;

   assign par_d = ^code_d;

   hamming_dec u_dec (
      .code_i (code_in),
      .par_i  (par_in),
      .dbl_o  (dbl_d),
      .data_o (dec_d),
      .syn_o  (syn_d),
      .corr_o (corr_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_q <= 1'b0;
         dbl_q <= 1'b0;
      end else begin
         par_q <= par_d;
         dbl_q <= dbl_d;
      end
   end

   assign par_out = par_q;
   assign err_dbl = dbl_q;
`else
   hamming_dec u_dec (
      .code_i (code_in),
      .data_o (dec_d),
      .syn_o  (syn_d),
      .corr_o (corr_d)
   );
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_q <= '0;
         dec_q  <= '0;
         syn_q  <= '0;
         corr_q <= 1'b0;
      end else begin
         code_q <= code_d;
         dec_q  <= dec_d;
         syn_q  <= syn_d;
         corr_q <= corr_d;
      end
   end

   assign data_out = code_q;
   assign dec_data = dec_q;
   assign syndrome = syn_q;
   assign err_corr = corr_q;

endmodule

// File: tb/tb_hamming.sv
// Scoreboard bench for hamming: stimulus pushes model expectations, a monitor pops and compares.
// Covers reset, fixed vectors, loopback sweep, single/double/invalid errors and async reset.
module tb_hamming;

   logic        clk;
   logic        rst;
   logic [7:0]  data_in;
   logic [11:0] data_out;
   logic [11:0] code_in;
   logic [7:0]  dec_data;
   logic [3:0]  syndrome;
   logic        err_corr;
`ifdef HAMMING_SECDED_EN
   logic        par_out;
   logic        par_in;
   logic        err_dbl;
`endif

   hamming dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .data_out (data_out),
      .code_in  (code_in),
      .dec_data (dec_data),
      .syndrome (syndrome),
      .err_corr (err_corr)
`ifdef HAMMING_SECDED_EN
      ,
      .par_out  (par_out),
      .par_in   (par_in),
      .err_dbl  (err_dbl)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_txn = 0;

   // Expected responses, one entry per clock edge that should be checked
   logic [11:0] q_code [$];
   logic [7:0]  q_dec  [$];
   logic [3:0]  q_syn  [$];
   logic        q_corr [$];
   logic        q_par  [$];
   logic        q_dbl  [$];
   string       q_tag  [$];

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model straight from the parity equations and position table
   function automatic logic [11:0] m_encode(input logic [7:0] d);
      logic [11:0] c;
      c     = '0;
      c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
      c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
      c[3]  = d[1] ^ d[2] ^ d[3] ^ d[7];
      c[7]  = d[4] ^ d[5] ^ d[6] ^ d[7];
      c[2]  = d[0];
      c[4]  = d[1];
      c[5]  = d[2];
      c[6]  = d[3];
      c[8]  = d[4];
      c[9]  = d[5];
      c[10] = d[6];
      c[11] = d[7];
      return c;
   endfunction

   function automatic logic [7:0] m_extract(input logic [11:0] c);
      return {c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
   endfunction

   // Syndrome as the XOR of the 1-based indices of all set bits
   function automatic logic [3:0] m_syn(input logic [11:0] c);
      int s;
      s = 0;
      for (int p = 1; p <= 12; p++) begin
         if (c[p-1]) s = s ^ p;
      end
      return 4'(s);
   endfunction

   task automatic m_decode(input logic [11:0] c, input logic pin,
                           output logic [7:0] d, output logic [3:0] s,
                           output logic corr, output logic dbl);
      logic [11:0] fixed;
      int          sv;
      logic        fix;
      s     = m_syn(c);
      sv    = int'(s);
      fixed = c;
`ifdef HAMMING_SECDED_EN
      begin
         logic p_all;
         p_all = (^c) ^ pin;
         fix   = (sv >= 1 && sv <= 12 && p_all);
         corr  = fix || (sv == 0 && p_all);
         dbl   = (sv != 0) && !fix;
      end
`else
      fix  = (sv >= 1 && sv <= 12);
      corr = fix;
      dbl  = 1'b0;
      if (pin) fix = fix;
`endif
      if (fix) fixed[sv-1] = ~fixed[sv-1];
      d = m_extract(fixed);
   endtask

   logic [7:0] last_d = 8'h00;

   // Drive one transaction at the falling edge; loop=1 feeds data_out back to code_in
   task automatic apply(input logic [7:0] d, input logic [11:0] c, input logic pin,
                        input bit loop, input string tag);
      logic [11:0] cexp;
      logic        pexp;
      logic [7:0]  ed;
      logic [3:0]  es;
      logic        ec;
      logic        eb;
      @(negedge clk);
      data_in = d;
      if (loop) begin
         cexp    = m_encode(last_d);
         pexp    = ^cexp;
         code_in = data_out;
`ifdef HAMMING_SECDED_EN
         par_in  = par_out;
`endif
      end else begin
         cexp    = c;
         pexp    = pin;
         code_in = c;
`ifdef HAMMING_SECDED_EN
         par_in  = pin;
`endif
      end
      m_decode(cexp, pexp, ed, es, ec, eb);
      q_code.push_back(m_encode(d));
      q_dec.push_back(ed);
      q_syn.push_back(es);
      q_corr.push_back(ec);
      q_par.push_back(^m_encode(d));
      q_dbl.push_back(eb);
      q_tag.push_back(tag);
      last_d = d;
   endtask

   // Monitor: every edge with a pending expectation is compared just after the edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q_code.size() > 0) begin
            string tag;
            tag = q_tag.pop_front();
            check({tag, ".data_out"}, data_out, q_code.pop_front());
            check({tag, ".dec_data"}, 12'(dec_data), 12'(q_dec.pop_front()));
            check({tag, ".syndrome"}, 12'(syndrome), 12'(q_syn.pop_front()));
            check({tag, ".err_corr"}, 12'(err_corr), 12'(q_corr.pop_front()));
`ifdef HAMMING_SECDED_EN
            check({tag, ".par_out"}, 12'(par_out), 12'(q_par.pop_front()));
            check({tag, ".err_dbl"}, 12'(err_dbl), 12'(q_dbl.pop_front()));
`else
            void'(q_par.pop_front());
            void'(q_dbl.pop_front());
`endif
            n_txn++;
            $display("txn %0d %s: data_out=%h dec_data=%h syndrome=%0d err_corr=%b",
                     n_txn, tag, data_out, dec_data, syndrome, err_corr);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_zero(input string tag);
      check({tag, ".data_out"}, data_out, 12'h000);
      check({tag, ".dec_data"}, 12'(dec_data), 12'h000);
      check({tag, ".syndrome"}, 12'(syndrome), 12'h000);
      check({tag, ".err_corr"}, 12'(err_corr), 12'h000);
`ifdef HAMMING_SECDED_EN
      check({tag, ".par_out"}, 12'(par_out), 12'h000);
      check({tag, ".err_dbl"}, 12'(err_dbl), 12'h000);
`endif
   endtask

   initial begin
      logic [11:0] base;
      logic [11:0] c;
      logic [7:0]  d;
      logic        pin;
      int          kind;
      int          b0;
      int          b1;

      rst     = 1'b1;
      data_in = 8'hA5;
      code_in = 12'h5A5;
`ifdef HAMMING_SECDED_EN
      par_in  = 1'b1;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_held");

      @(negedge clk);
      rst = 1'b0;
      apply(8'h00, 12'h000, 1'b0, 1'b0, "first_zero");
      apply(8'h01, 12'h007, 1'b1, 1'b0, "enc_01");
      apply(8'h80, 12'h888, 1'b1, 1'b0, "enc_80");
      apply(8'hFF, 12'hF77, 1'b1, 1'b0, "enc_FF");
      apply(8'h3C, 12'h017, 1'b1, 1'b0, "flip_pos5");
      apply(8'hC3, 12'h006, 1'b1, 1'b0, "flip_pos1");
      apply(8'h5A, m_encode(8'h96) ^ 12'h801, ^m_encode(8'h96), 1'b0, "syn13");
`ifdef HAMMING_SECDED_EN
      apply(8'h01, 12'h004, 1'b1, 1'b0, "secded_dbl");
      apply(8'h01, 12'h007, 1'b0, 1'b0, "secded_par_only");
`endif

      for (int i = 0; i < 256; i++) begin
         apply(8'(i), 12'h000, 1'b0, 1'b1, "loopback");
      end

      for (int i = 0; i < 200; i++) begin
         d    = 8'($urandom);
         base = m_encode(8'($urandom));
         pin  = ^base;
         kind = int'($urandom_range(0, 4));
         b0   = int'($urandom_range(0, 11));
         b1   = (b0 + 1 + int'($urandom_range(0, 10))) % 12;
         c    = base;
         case (kind)
            1: c[b0] = ~c[b0];
            2: begin c[b0] = ~c[b0]; c[b1] = ~c[b1]; end
            3: c = 12'($urandom);
            4: pin = ~pin;
            default: ;
         endcase
         apply(d, c, pin, 1'b0, "random");
      end

      // Async reset between edges with a nonzero result already on the outputs
      apply(8'hFF, m_encode(8'hFF) ^ 12'h010, 1'b1, 1'b0, "pre_reset");
      @(negedge clk);
      data_in = 8'h7E;
      code_in = 12'hABC;
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_assert");
      @(posedge clk);
      #1;
      check_zero("inflight_discard");
      #2;
      rst = 1'b0;
      #1;
      check_zero("after_release");
      apply(8'h80, 12'h888, 1'b1, 1'b0, "resume");
      apply(8'h01, 12'h017, 1'b1, 1'b0, "resume2");

      repeat (2) @(posedge clk);
      #2;
      check("queue_drained", 12'(q_code.size()), 12'h000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
